// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the mips data-memory responder.
// Holds the FSM state encoding, the latched request record and the byte-merge function.
package mips_mem_pkg;

  localparam int WORD_W  = 32;
  localparam int WADDR_W = 30;
  localparam int LANES   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic [WADDR_W-1:0] addr;
    logic [LANES-1:0]   mask;
    logic [WORD_W-1:0]  data;
  } dmem_req_t;

  // Replace each lane of old_word whose mask bit is set with the same lane of new_word.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] new_word,
    input logic [LANES-1:0]  mask
  );
    logic [WORD_W-1:0] result;
    result = old_word;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) result[8*i +: 8] = new_word[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Single-port DEPTH x 32 word store with per-byte write enables and an asynchronous read.
module mem_word_array
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [LANES-1:0]         write_en,
  input  logic [WORD_W-1:0]        write_data,
  output logic [WORD_W-1:0]        read_data
);

  logic [WORD_W-1:0] words [DEPTH];

  // NOTE: the storage has no reset; clearing a RAM would cost a cycle per word.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (write_en[i]) words[index][8*i +: 8] <= write_data[8*i +: 8];
    end
  end

  assign read_data = words[index];

endmodule

// File: rtl/mips_dmem_responder.sv
// Responder for the core data-memory port: one request at a time, answered LATENCY cycles later.
// Macro MIPS_DMEM_RANGE_CHECK_EN enables the out-of-range exception; otherwise addresses alias.
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int                 DEPTH      = 1024,
  parameter logic [WADDR_W-1:0] BASE_WADDR = 30'h04000000,
  parameter int                 LATENCY    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req,
  output logic               mem_ready,
  input  logic [WADDR_W-1:0] mem_addr,
  input  logic [LANES-1:0]   mem_write_en,
  input  logic [WORD_W-1:0]  mem_data_in,
  output logic               mem_resp_valid,
  output logic [WORD_W-1:0]  mem_data_out,
  output logic               mem_excpt
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  dmem_state_t       state;
  logic [3:0]        cnt;
  dmem_req_t         req_q;
  dmem_req_t         cur;
  logic              accept;
  logic              fire;
  logic              in_range;
  logic [IDX_W-1:0]  index;
  logic [LANES-1:0]  wr_mask;
  logic [WORD_W-1:0] rdata;
  logic [WORD_W-1:0] resp_data;

  assign accept = (state == IDLE) && mem_req;

  // With LATENCY==1 the access happens on the accept edge, before req_q holds the request.
  assign cur  = (state == IDLE) ? '{addr: mem_addr, mask: mem_write_en, data: mem_data_in}
                                : req_q;
  assign fire = ((state == WAIT) && (cnt == 4'd1)) || ((LATENCY == 1) && accept);

`ifdef MIPS_DMEM_RANGE_CHECK_EN
  localparam logic [WADDR_W:0] DEPTH_EXT = (WADDR_W + 1)'(DEPTH);
  logic [WADDR_W:0] offset;

  // One extra bit catches the borrow when the address lies below the base.
  assign offset   = {1'b0, cur.addr} - {1'b0, BASE_WADDR};
  assign in_range = !offset[WADDR_W] && (offset < DEPTH_EXT);
  assign index    = offset[IDX_W-1:0];
`else
  assign in_range = 1'b1;
  assign index    = IDX_W'(cur.addr - BASE_WADDR);
`endif

  assign wr_mask   = (fire && in_range) ? cur.mask : '0;
  assign resp_data = in_range ? merge_bytes(rdata, cur.data, cur.mask) : '0;

  mem_word_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk       (clk),
    .index     (index),
    .write_en  (wr_mask),
    .write_data(cur.data),
    .read_data (rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      req_q          <= '0;
      mem_ready      <= 1'b1;
      mem_resp_valid <= 1'b0;
      mem_data_out   <= '0;
      mem_excpt      <= 1'b0;
    end else begin
      mem_resp_valid <= 1'b0;
      if (fire) begin
        mem_resp_valid <= 1'b1;
        mem_data_out   <= resp_data;
        mem_excpt      <= !in_range;
      end
      unique case (state)
        IDLE: begin
          if (mem_req) begin
            req_q     <= cur;
            cnt       <= CNT_INIT;
            state     <= (LATENCY > 1) ? WAIT : RESP;
            mem_ready <= 1'b0;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP: begin
          state     <= IDLE;
          mem_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          mem_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Self-checking bench for mips_dmem_responder: directed table, corner sequences, random vs model.
module tb_mips_dmem_responder;

  localparam int          DEPTH = 1024;
  localparam logic [29:0] BASE  = 30'h04000000;
  localparam int          LAT   = 2;
  localparam int          WIN   = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, ready, rv, excpt;
  logic [29:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata, rdata;

  logic        req1, ready1, rv1, excpt1;
  logic [31:0] rdata1;
  logic        req15, ready15, rv15, excpt15;
  logic [31:0] rdata15;

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH(DEPTH), .BASE_WADDR(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_req(req), .mem_ready(ready), .mem_addr(addr),
    .mem_write_en(mask), .mem_data_in(wdata), .mem_resp_valid(rv),
    .mem_data_out(rdata), .mem_excpt(excpt)
  );

  mips_dmem_responder #(.DEPTH(DEPTH), .BASE_WADDR(BASE), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .mem_req(req1), .mem_ready(ready1), .mem_addr(addr),
    .mem_write_en(mask), .mem_data_in(wdata), .mem_resp_valid(rv1),
    .mem_data_out(rdata1), .mem_excpt(excpt1)
  );

  mips_dmem_responder #(.DEPTH(DEPTH), .BASE_WADDR(BASE), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .mem_req(req15), .mem_ready(ready15), .mem_addr(addr),
    .mem_write_en(mask), .mem_data_in(wdata), .mem_resp_valid(rv15),
    .mem_data_out(rdata15), .mem_excpt(excpt15)
  );

  typedef struct {
    logic [29:0] a;
    logic [3:0]  m;
    logic [31:0] d;
    logic [31:0] exp_data;
    logic        exp_x;
  } vec_t;

  vec_t        tbl [12];
  logic [31:0] model [DEPTH];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request on the main instance; lat counts cycles from accept edge to the
  // edge at which the requester samples the response.
  task automatic do_txn(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d,
                        output logic [31:0] got, output logic gx, output int lat);
    int guard;
    addr = a; mask = m; wdata = d; req = 1'b1;
    guard = 0;
    while (!ready && guard < 50) begin tick(); guard++; end
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    tick();
    req = 1'b0;
    lat = 1;
    while (!rv && lat < 40) begin tick(); lat++; end
    got = rdata;
    gx  = excpt;
    check("ready_low_in_resp", 32'(ready), 32'd0);
    tick();
    check("resp_pulse_one_cycle", 32'(rv), 32'd0);
    check("ready_after_resp", 32'(ready), 32'd1);
  endtask

  // Reference: plain range test and modular aliasing, byte lanes merged one at a time.
  task automatic ref_access(input logic [29:0] a, input logic [3:0] m, input logic [31:0] d,
                            output logic [31:0] exp, output logic ex);
    longint off;
    int     idx;
    off = longint'(a) - longint'(BASE);
`ifdef MIPS_DMEM_RANGE_CHECK_EN
    if (off < 0 || off >= DEPTH) begin
      exp = 32'h0;
      ex  = 1'b1;
      return;
    end
`endif
    idx = int'(((off % DEPTH) + DEPTH) % DEPTH);
    for (int i = 0; i < 4; i++) begin
      if (m[i]) model[idx][8*i +: 8] = d[8*i +: 8];
    end
    exp = model[idx];
    ex  = 1'b0;
  endtask

  initial begin
    logic [31:0] got, exp;
    logic        gx, ex;
    int          lat, n, k, sel;
    logic [29:0] a;
    logic [3:0]  m;
    logic [31:0] d;

`ifdef MIPS_DMEM_RANGE_CHECK_EN
    tbl[4]  = '{BASE + 30'(DEPTH),     4'h0, 32'h0,        32'h0,        1'b1};
    tbl[7]  = '{BASE + 30'(DEPTH + 1), 4'h0, 32'h0,        32'h0,        1'b1};
    tbl[9]  = '{BASE + 30'(DEPTH + 2), 4'hF, 32'hAAAAAAAA, 32'h0,        1'b1};
    tbl[10] = '{BASE + 30'd2,          4'h0, 32'h0,        32'h01020304, 1'b0};
    tbl[11] = '{BASE - 30'(DEPTH - 1), 4'h0, 32'h0,        32'h0,        1'b1};
`else
    tbl[4]  = '{BASE + 30'(DEPTH),     4'h0, 32'h0,        32'hDEADAAEF, 1'b0};
    tbl[7]  = '{BASE + 30'(DEPTH + 1), 4'h0, 32'h0,        32'h11FEF044, 1'b0};
    tbl[9]  = '{BASE + 30'(DEPTH + 2), 4'hF, 32'hAAAAAAAA, 32'hAAAAAAAA, 1'b0};
    tbl[10] = '{BASE + 30'd2,          4'h0, 32'h0,        32'hAAAAAAAA, 1'b0};
    tbl[11] = '{BASE - 30'(DEPTH - 1), 4'h0, 32'h0,        32'h11FEF044, 1'b0};
`endif
    tbl[0] = '{BASE,          4'hF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{BASE,          4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2] = '{BASE,          4'h2, 32'h0000AA00, 32'hDEADAAEF, 1'b0};
    tbl[3] = '{BASE,          4'h0, 32'h0,        32'hDEADAAEF, 1'b0};
    tbl[5] = '{BASE + 30'd1,  4'hF, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    tbl[6] = '{BASE + 30'd1,  4'h9, 32'h11223344, 32'h11FEF044, 1'b0};
    tbl[8] = '{BASE + 30'd2,  4'hF, 32'h01020304, 32'h01020304, 1'b0};

    rst = 1'b1; req = 1'b0; req1 = 1'b0; req15 = 1'b0;
    addr = '0; mask = '0; wdata = '0;
    tick(); tick();
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_resp_valid", 32'(rv), 32'd0);
    check("reset_data_out", rdata, 32'h0);
    check("reset_excpt", 32'(excpt), 32'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      do_txn(tbl[i].a, tbl[i].m, tbl[i].d, got, gx, lat);
      check($sformatf("tbl%0d_data", i), got, tbl[i].exp_data);
      check($sformatf("tbl%0d_excpt", i), 32'(gx), 32'(tbl[i].exp_x));
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(LAT));
    end

    // Reset during WAIT must drop the pending store.
    do_txn(BASE + 30'd7, 4'hF, 32'h12345678, got, gx, lat);
    addr = BASE + 30'd7; mask = 4'hF; wdata = 32'hFFFFFFFF; req = 1'b1;
    tick();
    req = 1'b0;
    rst = 1'b1;
    #1;
    check("midwait_rst_ready", 32'(ready), 32'd1);
    check("midwait_rst_valid", 32'(rv), 32'd0);
    check("midwait_rst_data", rdata, 32'h0);
    check("midwait_rst_excpt", 32'(excpt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_txn(BASE + 30'd7, 4'h0, 32'h0, got, gx, lat);
    check("dropped_store_no_write", got, 32'h12345678);

    // Fill the random window so the model knows every word it will be asked about.
    for (int i = 0; i < WIN; i++) begin
      d = $urandom;
      model[i] = d;
      do_txn(BASE + 30'(i), 4'hF, d, got, gx, lat);
      check("window_fill", got, d);
    end

    for (int t = 0; t < 150; t++) begin
      k   = int'($urandom % WIN);
      sel = int'($urandom % 8);
      if (sel == 0)      a = BASE + 30'(DEPTH + k);
      else if (sel == 1) a = BASE - 30'(DEPTH - k);
      else               a = BASE + 30'(k);
      m = ($urandom % 3 == 0) ? 4'h0 : 4'($urandom);
      d = $urandom;
      ref_access(a, m, d, exp, ex);
      do_txn(a, m, d, got, gx, lat);
      check("rand_data", got, exp);
      check("rand_excpt", 32'(gx), 32'(ex));
      if (lat != LAT) check("rand_latency", 32'(lat), 32'(LAT));
    end

    // Request held through WAIT/RESP with a changing address: only the first is served.
    addr = BASE + 30'd3; mask = 4'h0; req = 1'b1;
    tick();
    addr = BASE + 30'd4;
    n = 1;
    while (!rv && n < 40) begin tick(); n++; end
    check("held_first_data", rdata, model[3]);
    check("held_first_latency", 32'(n), 32'(LAT));
    tick();
    check("held_ready_reasserts", 32'(ready), 32'd1);
    check("held_no_extra_resp", 32'(rv), 32'd0);
    tick();
    req = 1'b0;
    n = 1;
    while (!rv && n < 40) begin tick(); n++; end
    check("held_second_data", rdata, model[4]);
    check("held_second_latency", 32'(n), 32'(LAT));
    tick();

    // Latency extremes on the other two instances.
    addr = BASE + 30'd9; mask = 4'h0;
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    n = 1;
    while (!rv1 && n < 40) begin tick(); n++; end
    check("latency1", 32'(n), 32'd1);
    check("latency1_excpt", 32'(excpt1), 32'd0);
    tick();
    check("latency1_ready", 32'(ready1), 32'd1);

    addr = BASE + 30'(DEPTH);
    req15 = 1'b1;
    tick();
    req15 = 1'b0;
    n = 1;
    while (!rv15 && n < 40) begin tick(); n++; end
    check("latency15", 32'(n), 32'd15);
`ifdef MIPS_DMEM_RANGE_CHECK_EN
    check("latency15_excpt", 32'(excpt15), 32'd1);
`else
    check("latency15_excpt", 32'(excpt15), 32'd0);
`endif
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
